// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
//
// Two-entry registered pipeline stage (main + skid) that sits between fetch and
// decode. Downstream outputs come only from the main registers, so there is no
// combinational path from the upstream side to the downstream side. InReady
// depends only on registered occupancy, which lets upstream keep streaming for
// one extra cycle after downstream stalls; that payload lands in the skid entry.
//
// Ports
//   Clk        : clock, all state changes on the rising edge
//   Rst        : synchronous active-high reset (overrides flush and handshakes)
//   InValid    : upstream payload valid
//   InReady    : stage accepts a payload this cycle (not full)
//   InAddr     : upstream instruction address
//   InInst     : upstream instruction
//   OutValid   : downstream payload valid
//   OutReady   : downstream accepts the payload
//   OutAddr    : instruction address presented to decode
//   OutInst    : instruction presented to decode
//   StallIn    : control-unit hold request, freezes the output side
//   FlushIn    : control-unit jump/flush request, empties the stage
//   Occupancy  : number of buffered entries (0..2)
//   StallCount : saturating count of cycles where a valid output was held
// -----------------------------------------------------------------------------
module pipe_skid_stage #(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] ADDR_INIT  = ADDR_WIDTH'(64'h8000_0000),
    parameter logic [INST_WIDTH-1:0] INST_INIT  = INST_WIDTH'(32'h0000_0013),
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [ADDR_WIDTH-1:0] InAddr,
    input  logic [INST_WIDTH-1:0] InInst,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [ADDR_WIDTH-1:0] OutAddr,
    output logic [INST_WIDTH-1:0] OutInst,
    input  logic                  StallIn,
    input  logic                  FlushIn,
    output logic [1:0]            Occupancy,
    output logic [CNT_WIDTH-1:0]  StallCount
);

    // The state encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stateT;

    stateT                 state, stateNext;
    logic [ADDR_WIDTH-1:0] mainAddr, mainAddrNext;
    logic [INST_WIDTH-1:0] mainInst, mainInstNext;
    logic [ADDR_WIDTH-1:0] skidAddr, skidAddrNext;
    logic [INST_WIDTH-1:0] skidInst, skidInstNext;
    logic [CNT_WIDTH-1:0]  stallCnt, stallCntNext;

    logic inFire;
    logic outOk;
    logic outFire;

    assign InReady    = (state != FULL);
    assign OutValid   = (state != EMPTY);
    assign OutAddr    = mainAddr;
    assign OutInst    = mainInst;
    assign Occupancy  = state;
    assign StallCount = stallCnt;

    assign inFire  = InValid & InReady;
    assign outOk   = OutReady & ~StallIn;
    assign outFire = OutValid & outOk;

    // Next-state and datapath selection. Flush wins over every handshake and
    // drops any payload accepted in the same cycle. Whenever the stage drains
    // to EMPTY the main entry is reloaded with the NOP bubble so decode sees a
    // clean, known value while OutValid is low. The stall counter lives here
    // too and ignores flush: a held valid output counts no matter what the
    // control unit does in that cycle.
    always_comb begin
        stateNext    = state;
        mainAddrNext = mainAddr;
        mainInstNext = mainInst;
        skidAddrNext = skidAddr;
        skidInstNext = skidInst;
        stallCntNext = stallCnt;

        if (OutValid && !outOk && (stallCnt != {CNT_WIDTH{1'b1}})) begin
            stallCntNext = stallCnt + CNT_WIDTH'(1);
        end

        if (FlushIn) begin
            stateNext    = EMPTY;
            mainAddrNext = ADDR_INIT;
            mainInstNext = INST_INIT;
            skidAddrNext = ADDR_INIT;
            skidInstNext = INST_INIT;
        end else begin
            case (state)
                EMPTY: begin
                    if (inFire) begin
                        stateNext    = ONE;
                        mainAddrNext = InAddr;
                        mainInstNext = InInst;
                    end
                end
                ONE: begin
                    if (inFire && outFire) begin
                        mainAddrNext = InAddr;
                        mainInstNext = InInst;
                    end else if (inFire) begin
                        stateNext    = FULL;
                        skidAddrNext = InAddr;
                        skidInstNext = InInst;
                    end else if (outFire) begin
                        stateNext    = EMPTY;
                        mainAddrNext = ADDR_INIT;
                        mainInstNext = INST_INIT;
                    end
                end
                FULL: begin
                    if (outFire) begin
                        stateNext    = ONE;
                        mainAddrNext = skidAddr;
                        mainInstNext = skidInst;
                    end
                end
                default: begin
                    stateNext    = EMPTY;
                    mainAddrNext = ADDR_INIT;
                    mainInstNext = INST_INIT;
                end
            endcase
        end
    end

    // State and payload registers. Reset discards both entries immediately,
    // even when the stage is full, and clears the stall counter.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= EMPTY;
            mainAddr <= ADDR_INIT;
            mainInst <= INST_INIT;
            skidAddr <= ADDR_INIT;
            skidInst <= INST_INIT;
            stallCnt <= '0;
        end else begin
            state    <= stateNext;
            mainAddr <= mainAddrNext;
            mainInst <= mainInstNext;
            skidAddr <= skidAddrNext;
            skidInst <= skidInstNext;
            stallCnt <= stallCntNext;
        end
    end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 64, the instruction-address payload width.
REQ-002 The block SHALL have parameter INST_WIDTH, default 32, the instruction payload width.
REQ-003 The block SHALL have parameter ADDR_INIT, default 64'h8000_0000, the address presented when the stage is empty, flushed or in reset.
REQ-004 The block SHALL have parameter INST_INIT, default 32'h0000_0013 (NOP), the instruction presented when the stage is empty, flushed or in reset.
REQ-005 The block SHALL have parameter CNT_WIDTH, default 16, the stall-counter width.
REQ-006 Port Clk, input, 1: the single clock; all state updates on its rising edge.
REQ-007 Port Rst, input, 1: reset, synchronous and active-high.
REQ-008 Port InValid, input, 1: the upstream payload is valid.
REQ-009 Port InReady, output, 1: the stage accepts a payload this cycle.
REQ-010 Port InAddr, input, ADDR_WIDTH: the upstream instruction address.
REQ-011 Port InInst, input, INST_WIDTH: the upstream instruction.
REQ-012 Port OutValid, output, 1: the downstream payload is valid.
REQ-013 Port OutReady, input, 1: downstream accepts the payload.
REQ-014 Port OutAddr, output, ADDR_WIDTH: the instruction address to decode.
REQ-015 Port OutInst, output, INST_WIDTH: the instruction to decode.
REQ-016 Port StallIn, input, 1: the control unit's hold request; it freezes the output side.
REQ-017 Port FlushIn, input, 1: the control unit's jump/flush request.
REQ-018 Port Occupancy, output, 2: the number of buffered entries (0..2).
REQ-019 Port StallCount, output, CNT_WIDTH: the saturating count of stalled cycles.

Function
REQ-020 The stage SHALL hold two entries, main and skid; OutAddr/OutInst/OutValid SHALL be driven only from main registers, with no combinational path from In* to Out*.
REQ-021 The stage SHALL define the qualifiers in_fire = InValid & InReady, out_ok = OutReady & ~StallIn, and out_fire = OutValid & out_ok.
REQ-022 InReady SHALL be 1 iff Occupancy != 2, and SHALL depend only on registered state, not on OutReady or StallIn.
REQ-023 The states SHALL be EMPTY (Occupancy 0), ONE (1) and FULL (2).
REQ-024 In EMPTY: in_fire -> ONE with main loaded from In*; otherwise stay in EMPTY.
REQ-025 In ONE with in_fire & out_fire: stay in ONE with main loaded from In* (zero-bubble throughput, 1 payload/cycle).
REQ-026 In ONE with in_fire & ~out_fire: go to FULL with skid loaded from In* and main unchanged.
REQ-027 In ONE with ~in_fire & out_fire: go to EMPTY.
REQ-028 In ONE with neither in_fire nor out_fire: hold.
REQ-029 In FULL with out_fire: go to ONE with main loaded from skid; in_fire cannot occur in FULL.
REQ-030 On any transition into EMPTY, main SHALL load ADDR_INIT/INST_INIT, so OutValid=0 with a NOP bubble presented.
REQ-031 Latency SHALL be 1 cycle from in_fire to OutValid when the stage was EMPTY or draining.
REQ-032 FlushIn SHALL have priority over all other events: next state EMPTY, main and skid loaded with ADDR_INIT/INST_INIT, and any same-cycle in_fire payload dropped.
REQ-033 Under StallIn=1 with FlushIn=0, the Out* signals SHALL remain bit-stable and acceptance SHALL continue until FULL.
REQ-034 StallCount SHALL increment by 1 in each cycle with OutValid=1 and out_ok=0.
REQ-035 StallCount SHALL saturate at all-ones and never wrap.
REQ-036 StallCount SHALL be unaffected by FlushIn.
REQ-037 Payload ordering SHALL be strictly FIFO, with no duplication or loss except under flush.

Reset
REQ-038 When Rst=1 at a rising edge, the stage SHALL go to EMPTY, load main and skid with ADDR_INIT/INST_INIT, and clear StallCount to 0; Rst SHALL override FlushIn and all handshakes.
REQ-039 After reset: OutValid=0, OutAddr=ADDR_INIT, OutInst=INST_INIT, InReady=1, Occupancy=0, StallCount=0.
REQ-040 Rst asserted mid-operation in FULL SHALL discard both entries in that same cycle.

Verification
REQ-041 Streaming: InValid=1 and OutReady=1 for 8 cycles with Addr 0x8000_0000+4k -> out sequence identical, 1-cycle latency, InReady constant at 1, Occupancy 1.
REQ-042 Backpressure: OutReady=0 after 2 accepts -> Occupancy=2, InReady=0, Out* frozen at the first payload, StallCount rising by 1/cycle; on release, both payloads are drained in order.
REQ-043 Flush in FULL with InValid=1 -> next cycle OutValid=0, OutAddr=0x8000_0000, OutInst=0x13, Occupancy=0, all 3 payloads absent downstream.
REQ-044 StallIn=1 with OutReady=1 for 5 cycles -> Out* unchanged, StallCount +5, no out_fire.
REQ-045 CNT_WIDTH=4 with a held stall of 20 cycles -> StallCount reads 15 and stays at 15.
REQ-046 Rst pulse in FULL -> next cycle matches REQ-039 and the next accepted payload appears with 1-cycle latency.
